spi_slave_driver: RTL and testbench
===================================

// Module: spi_slave_driver
// PURPOSE
//  SPI slave (responder) for the CPOL=0, CPHA=0, LSB-first, 8-bit SPI protocol. Pairs with spi_master_driver.
//  Oversamples SCLK/CS/MOSI on the system clock, shifts in one byte per frame and shifts out a preloaded byte.
//  Sits between the SPI pins and a peripheral or bus-side register block in the same clock domain as the master.
// PARAMETERS
//  DEFAULT_TX  8'hFF  byte shifted out when no tx byte was loaded before a byte boundary (underrun)
// PORTS
//  clk_i        in   1  system clock; all logic on posedge
//  rst_i        in   1  synchronous, active-high reset
//  spi_cs_i     in   1  chip select, active low (0 = selected)
//  spi_sclk_i   in   1  SPI clock from master, idle 0
//  spi_mosi_i   in   1  master-to-slave data
//  spi_miso_o   out  1  slave-to-master data
//  tx_data_bi   in   8  byte to send in the next frame
//  tx_load_i    in   1  1-cycle strobe: tx_data_bi -> tx holding register
//  tx_ready_o   out  1  1 = tx holding register empty, a load is accepted
//  rx_data_bo   out  8  last byte received; held until the next byte completes
//  rx_valid_o   out  1  1-cycle pulse, rx_data_bo updated this cycle
//  busy_o       out  1  1 while a byte is in progress (CS low and bit count != 0)
// BEHAVIOUR
//  Reset: spi_miso_o=0, tx_ready_o=1, rx_data_bo=0, rx_valid_o=0, busy_o=0, bit_cnt=0, state=IDLE, holding reg empty.
//  Input path: CS, SCLK and MOSI pass through the same register pipeline, so they stay mutually aligned.
//    Pipeline depth SYNC_LAT is set by CONFIGURATION.
//  An extra register on SCLK gives the rise and fall edge detect.
//  FSM:
//    IDLE   -> LOAD when synchronized CS falls.
//    LOAD   (1 cycle): shift_tx <= holding reg if full, else DEFAULT_TX; holding reg marked empty;
//           bit_cnt <= 0; go SHIFT.
//    SHIFT  on SCLK rise: rx_shift <= {mosi_s, rx_shift[7:1]}; shift_tx <= shift_tx >> 1; bit_cnt++.
//           When bit_cnt==7 at the rise: rx_data_bo <= assembled byte, rx_valid_o=1 next cycle,
//           go LOAD so the next byte's bit0 is on MISO before the next rise.
//    any    -> IDLE when synchronized CS rises. Highest priority, even mid-byte.
//           A partial byte is discarded: no rx_valid; the holding reg is untouched.
//  MISO = shift_tx[0] while CS low (sync), else 0.
//    Advances right after each rising-edge sample, not on the falling edge. This is legal because the
//    master captures MISO on the same clock it raises SCLK.
//    The first bit is valid by LOAD+1, i.e. SYNC_LAT+2 clocks after the CS pin falls.
//  Timing requirement: each SCLK level is held >= 2 clk_i cycles (master CLK_NOPS >= 1).
//    The master's CS-low-to-first-rise time is >= SYNC_LAT+3 clocks.
//  Holding register:
//    tx_load_i while tx_ready_o=1: accept, tx_ready_o=0 next cycle.
//    tx_load_i while tx_ready_o=0: overwrite the pending byte, no error.
//    tx_load_i in the same cycle as LOAD consumes the holding reg: LOAD takes the old content,
//      the new byte is written, and tx_ready_o stays 0.
//  rx_valid_o fires exactly once per complete 8-bit byte. Back-to-back bytes under one CS are supported.
// CONFIGURATION
//  SPI_SLAVE_SYNC_EN defined: 2-flop synchronizers on CS/SCLK/MOSI (SYNC_LAT=2), for asynchronous pins.
//  Not defined: single register stage (SYNC_LAT=1), for the master in the same clk_i domain.
//    All other behaviour is identical.
// STRUCTURE
//  spi_defs.vh: state localparams (IDLE=0, LOAD=1, SHIFT=2), SPI_DATA_W=8, SPI_BIT_CNT_W=3.
//    Shared with spi_master_driver.
//  Sub-module spi_sync_edge: N-stage synchronizer plus rise/fall pulse outputs.
//    Instantiated once for SCLK and once for CS; MOSI uses the same depth via a plain delay line.
// TESTING (bench: spi_master_driver CLK_NOPS=1 <-> spi_slave_driver, same clk_i; both macro settings)
//  1. Load 8'hA5, master start with 8'h3C, CS low
//     -> master data_out_bo=8'hA5; slave rx_data_bo=8'h3C with one rx_valid_o pulse.
//  2. No load, master sends 8'h81
//     -> master receives 8'hFF (DEFAULT_TX); slave rx 8'h81; tx_ready_o stays 1.
//  3. Two back-to-back bytes under one CS, loads 8'h01 then 8'h02 (second load after tx_ready_o returns 1)
//     -> master gets 01 then 02; two rx_valid pulses with the master's bytes.
//  4. CS raised after 4 SCLK rises
//     -> no rx_valid, busy_o=0, next frame starts at bit0 and transfers 8'h5A correctly.
//  5. rst_i asserted mid-byte for 1 cycle -> all outputs at reset values next cycle; next full frame correct.
//  6. tx_load_i twice (8'h11 then 8'h22) before a frame -> master receives 8'h22; tx_ready_o=0 until LOAD.

Source files
------------

// File: rtl/spi_slave_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_driver_pkg
//  Description : Shared types and constants for the SPI slave (CPOL=0,
//                CPHA=0, LSB-first, 8-bit). Holds the FSM state encoding,
//                the data/bit-count widths and the input pipeline depth.
//  Config      : SPI_SLAVE_SYNC_EN defined   -> SYNC_LAT = 2 (async pins)
//                SPI_SLAVE_SYNC_EN undefined -> SYNC_LAT = 1 (same clk domain)
//  Revision    : 1.0  initial release
// ============================================================================
package spi_slave_driver_pkg;

    localparam int SPI_DATA_W    = 8;
    localparam int SPI_BIT_CNT_W = 3;

    // Bit index of the last bit in a byte; reaching it on a rise completes the byte.
    localparam logic [SPI_BIT_CNT_W-1:0] C_BIT_CNT_LAST = SPI_BIT_CNT_W'(SPI_DATA_W - 1);

`ifdef SPI_SLAVE_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_slave_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_driver_if
//  Description : SPI pin and byte-side signal bundle for spi_slave_driver.
//                slave  modport : seen from the SPI slave block
//                master modport : seen from the SPI master / bus side
//  Signals     : spi_cs_i, spi_sclk_i, spi_mosi_i, spi_miso_o (SPI pins)
//                tx_data_bi, tx_load_i, tx_ready_o (transmit holding reg)
//                rx_data_bo, rx_valid_o, busy_o (receive side / status)
//  Revision    : 1.0  initial release
// ============================================================================
interface spi_slave_driver_if;
    import spi_slave_driver_pkg::*;

    logic                  spi_cs_i;
    logic                  spi_sclk_i;
    logic                  spi_mosi_i;
    logic                  spi_miso_o;
    logic [SPI_DATA_W-1:0] tx_data_bi;
    logic                  tx_load_i;
    logic                  tx_ready_o;
    logic [SPI_DATA_W-1:0] rx_data_bo;
    logic                  rx_valid_o;
    logic                  busy_o;

    modport slave (
        input  spi_cs_i, spi_sclk_i, spi_mosi_i, tx_data_bi, tx_load_i,
        output spi_miso_o, tx_ready_o, rx_data_bo, rx_valid_o, busy_o
    );

    modport master (
        output spi_cs_i, spi_sclk_i, spi_mosi_i, tx_data_bi, tx_load_i,
        input  spi_miso_o, tx_ready_o, rx_data_bo, rx_valid_o, busy_o
    );

endinterface
`default_nettype wire

// File: rtl/spi_slave_driver_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_driver_sync_edge
//  Description : STAGES-deep register pipeline on one input bit plus an
//                extra register for rise/fall pulse detection.
//  Ports       : clk_i   in  system clock
//                rst_i   in  synchronous active-high reset
//                d_i     in  raw input
//                q_o     out pipelined input (STAGES clocks late)
//                rise_o  out 1-cycle pulse on 0->1 of q_o
//                fall_o  out 1-cycle pulse on 1->0 of q_o
//  Revision    : 1.0  initial release
// ============================================================================
module spi_slave_driver_sync_edge #(
    parameter int   STAGES  = 1,
    parameter logic RST_VAL = 1'b0
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic d_i,
    output logic      q_o,
    output logic      rise_o,
    output logic      fall_o
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign q_o    = r_sync[STAGES-1];
    assign rise_o =  r_sync[STAGES-1] & ~r_prev;
    assign fall_o = ~r_sync[STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave_driver.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_driver
//  Description : SPI slave, CPOL=0 CPHA=0, LSB-first, 8-bit frames.
//                Oversamples CS/SCLK/MOSI on clk_i, shifts in one byte per
//                8 SCLK rises and shifts out a preloaded byte (DEFAULT_TX on
//                underrun). Back-to-back bytes under one CS are supported.
//  Parameters  : DEFAULT_TX  byte sent when the holding register is empty
//  Ports       : clk_i  in  system clock
//                rst_i  in  synchronous active-high reset
//                bus    spi_slave_driver_if.slave (SPI pins, tx holding
//                       register load/ready, rx byte/valid, busy)
//  Config      : SPI_SLAVE_SYNC_EN selects 2-flop input synchronizers
//                (see spi_slave_driver_pkg); default is a single stage.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_slave_driver
    import spi_slave_driver_pkg::*;
#(
    parameter logic [SPI_DATA_W-1:0] DEFAULT_TX = 8'hFF
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    spi_slave_driver_if.slave    bus
);

    // ------------------------------------------------------------------
    // Input pipeline: CS, SCLK and MOSI all see SYNC_LAT stages so they
    // remain mutually aligned after sampling.
    // ------------------------------------------------------------------
    logic w_cs_s, w_cs_rise, w_cs_fall;
    logic w_sclk_s, w_sclk_rise, w_sclk_fall;
    logic w_mosi_s;

    // CS resets high (deselected) so releasing reset never looks like a frame start.
    spi_slave_driver_sync_edge #(
        .STAGES  (SYNC_LAT),
        .RST_VAL (1'b1)
    ) u_cs_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (bus.spi_cs_i),
        .q_o    (w_cs_s),
        .rise_o (w_cs_rise),
        .fall_o (w_cs_fall)
    );

    spi_slave_driver_sync_edge #(
        .STAGES  (SYNC_LAT),
        .RST_VAL (1'b0)
    ) u_sclk_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (bus.spi_sclk_i),
        .q_o    (w_sclk_s),
        .rise_o (w_sclk_rise),
        .fall_o (w_sclk_fall)
    );

    // MOSI needs no edge detect, only the same delay as the other two pins.
    logic [SYNC_LAT-1:0] r_mosi_dly;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mosi_dly <= '0;
        end else begin
            r_mosi_dly[0] <= bus.spi_mosi_i;
            for (int i = 1; i < SYNC_LAT; i++) begin
                r_mosi_dly[i] <= r_mosi_dly[i-1];
            end
        end
    end

    assign w_mosi_s = r_mosi_dly[SYNC_LAT-1];

    // ------------------------------------------------------------------
    // Byte engine
    // ------------------------------------------------------------------
    state_t                   r_state;
    logic [SPI_BIT_CNT_W-1:0] r_bit_cnt;
    logic [SPI_DATA_W-1:0]    r_shift_tx;
    logic [SPI_DATA_W-1:0]    r_rx_shift;
    logic [SPI_DATA_W-1:0]    r_rx_data;
    logic                     r_rx_valid;
    logic [SPI_DATA_W-1:0]    r_hold;
    logic                     r_tx_ready;

    logic [SPI_DATA_W-1:0]    w_rx_byte;
    logic                     w_consume;

    assign w_rx_byte = {w_mosi_s, r_rx_shift[SPI_DATA_W-1:1]};

    // A CS rise cancels the LOAD, so the holding register is only drained
    // when the frame is still active.
    assign w_consume = (r_state == ST_LOAD) && !w_cs_rise;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_shift_tx <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_hold     <= '0;
            r_tx_ready <= 1'b1;
        end else begin
            r_rx_valid <= 1'b0;

            // Holding register: a new load always wins over the consume,
            // so a load coincident with LOAD leaves the register full.
            if (bus.tx_load_i) begin
                r_hold     <= bus.tx_data_bi;
                r_tx_ready <= 1'b0;
            end else if (w_consume) begin
                r_tx_ready <= 1'b1;
            end

            if (w_cs_rise) begin
                // Deselect aborts any partial byte without reporting it.
                r_state   <= ST_IDLE;
                r_bit_cnt <= '0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_cs_fall) begin
                            r_state <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        // r_hold here is the pre-load content, even if a
                        // load arrives this same cycle.
                        r_shift_tx <= r_tx_ready ? DEFAULT_TX : r_hold;
                        r_bit_cnt  <= '0;
                        r_state    <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (w_sclk_rise) begin
                            r_rx_shift <= w_rx_byte;
                            r_shift_tx <= r_shift_tx >> 1;
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == C_BIT_CNT_LAST) begin
                                r_rx_data  <= w_rx_byte;
                                r_rx_valid <= 1'b1;
                                // Reload immediately so the next byte's bit0
                                // is on MISO before the next rise.
                                r_state    <= ST_LOAD;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // MISO advances right after each sampled rise; the master captures it
    // on the clock it raises SCLK, so no falling-edge launch is needed.
    assign bus.spi_miso_o = ~w_cs_s & r_shift_tx[0];
    assign bus.tx_ready_o = r_tx_ready;
    assign bus.rx_data_bo = r_rx_data;
    assign bus.rx_valid_o = r_rx_valid;
    assign bus.busy_o     = ~w_cs_s & (r_bit_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_driver
//  Description : Self-checking bench for spi_slave_driver. The bench acts as
//                the SPI master (CPOL=0, CPHA=0, LSB-first, SCLK levels held
//                2 clocks) and as the tx-side producer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_slave_driver;
    import spi_slave_driver_pkg::*;

    localparam logic [7:0] C_DEFAULT_TX = 8'hFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_driver_if bus ();

    spi_slave_driver #(
        .DEFAULT_TX (C_DEFAULT_TX)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // rx monitor: every cycle rx_valid is high counts as one reported byte
    int         rx_cnt = 0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (!rst && bus.rx_valid_o === 1'b1) begin
            rx_cnt++;
            rx_q.push_back(bus.rx_data_bo);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic expect_rx(input string nm, input logic [7:0] e);
        if (rx_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: no rx byte captured, expected %02h", nm, e);
        end else begin
            chk(nm, rx_q.pop_front(), e);
        end
    endtask

    task automatic do_load(input logic [7:0] b);
        bus.tx_data_bi = b;
        bus.tx_load_i  = 1'b1;
        tick(1);
        bus.tx_load_i  = 1'b0;
    endtask

    // One byte as master; optional loads (nl = 0..2) issued during bit 3.
    task automatic xfer_byte(input logic [7:0] m, input int nbits, input int nl,
                             input logic [7:0] l0, input logic [7:0] l1,
                             output logic [7:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi_i = m[i];
            tick(2);
            got[i] = bus.spi_miso_o;
            bus.spi_sclk_i = 1'b1;
            tick(1);
            if (i == 3 && nl >= 1) do_load(l0);
            if (i == 3 && nl >= 2) do_load(l1);
            tick(1);
            bus.spi_sclk_i = 1'b0;
        end
    endtask

    task automatic frame_begin();
        rx_q.delete();
        bus.spi_cs_i = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        tick(3);
        bus.spi_cs_i = 1'b1;
        tick(6);
    endtask

    typedef struct {
        logic [7:0] mosi;
        int         nload;
        logic [7:0] l0;
        logic [7:0] l1;
        logic [7:0] exp_miso;
    } vec_t;

    initial begin
        vec_t       vecs[5];
        logic [7:0] got, g0, g1;
        int         c0;

        vecs[0] = '{mosi: 8'h3C, nload: 1, l0: 8'hA5, l1: 8'h00, exp_miso: 8'hA5};
        vecs[1] = '{mosi: 8'h81, nload: 0, l0: 8'h00, l1: 8'h00, exp_miso: 8'hFF};
        vecs[2] = '{mosi: 8'hC7, nload: 2, l0: 8'h11, l1: 8'h22, exp_miso: 8'h22};
        vecs[3] = '{mosi: 8'h00, nload: 1, l0: 8'h00, l1: 8'h00, exp_miso: 8'h00};
        vecs[4] = '{mosi: 8'hFF, nload: 1, l0: 8'h7E, l1: 8'h00, exp_miso: 8'h7E};

        bus.spi_cs_i   = 1'b1;
        bus.spi_sclk_i = 1'b0;
        bus.spi_mosi_i = 1'b0;
        bus.tx_data_bi = '0;
        bus.tx_load_i  = 1'b0;
        rst            = 1'b1;
        tick(3);

        // Reset state
        chk("reset_miso",     bus.spi_miso_o, 0);
        chk("reset_tx_ready", bus.tx_ready_o, 1);
        chk("reset_rx_data",  bus.rx_data_bo, 0);
        chk("reset_rx_valid", bus.rx_valid_o, 0);
        chk("reset_busy",     bus.busy_o,     0);
        rst = 1'b0;
        tick(2);

        // Single-byte frames from the vector table
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].nload >= 1) do_load(vecs[v].l0);
            if (vecs[v].nload >= 2) do_load(vecs[v].l1);
            chk($sformatf("vec%0d_ready_pre", v), bus.tx_ready_o, (vecs[v].nload == 0));
            c0 = rx_cnt;
            frame_begin();
            xfer_byte(vecs[v].mosi, 8, 0, 8'h00, 8'h00, got);
            frame_end();
            chk($sformatf("vec%0d_miso", v), got, vecs[v].exp_miso);
            chk($sformatf("vec%0d_rx_pulses", v), rx_cnt - c0, 1);
            expect_rx($sformatf("vec%0d_rx_data", v), vecs[v].mosi);
            chk($sformatf("vec%0d_ready_post", v), bus.tx_ready_o, 1);
        end

        // Back-to-back bytes under one CS; second load after first is consumed
        do_load(8'h01);
        c0 = rx_cnt;
        frame_begin();
        xfer_byte(8'h9A, 8, 1, 8'h02, 8'h00, g0);
        xfer_byte(8'h4E, 8, 0, 8'h00, 8'h00, g1);
        frame_end();
        chk("b2b_miso0", g0, 8'h01);
        chk("b2b_miso1", g1, 8'h02);
        chk("b2b_rx_pulses", rx_cnt - c0, 2);
        expect_rx("b2b_rx0", 8'h9A);
        expect_rx("b2b_rx1", 8'h4E);

        // Load coincident with the LOAD cycle: old byte goes out, new byte stays pending
        do_load(8'h11);
        rx_q.delete();
        bus.spi_cs_i = 1'b0;
        tick(SYNC_LAT + 1);
        do_load(8'h33);
        chk("coinc_ready_after_load", bus.tx_ready_o, 0);
        tick(1);
        xfer_byte(8'h27, 8, 0, 8'h00, 8'h00, g0);
        xfer_byte(8'hD8, 8, 0, 8'h00, 8'h00, g1);
        frame_end();
        chk("coinc_miso0", g0, 8'h11);
        chk("coinc_miso1", g1, 8'h33);
        chk("coinc_ready_post", bus.tx_ready_o, 1);

        // CS raised after 4 rises: partial byte dropped, next frame clean
        c0 = rx_cnt;
        frame_begin();
        xfer_byte(8'hE3, 4, 0, 8'h00, 8'h00, got);
        tick(2);
        chk("abort_busy_mid", bus.busy_o, 1);
        bus.spi_cs_i = 1'b1;
        tick(SYNC_LAT + 2);
        chk("abort_busy_after", bus.busy_o, 0);
        chk("abort_rx_pulses", rx_cnt - c0, 0);
        tick(4);
        do_load(8'h96);
        c0 = rx_cnt;
        frame_begin();
        xfer_byte(8'h5A, 8, 0, 8'h00, 8'h00, got);
        frame_end();
        chk("post_abort_miso", got, 8'h96);
        chk("post_abort_rx_pulses", rx_cnt - c0, 1);
        expect_rx("post_abort_rx", 8'h5A);

        // Reset pulse mid-byte
        c0 = rx_cnt;
        frame_begin();
        xfer_byte(8'hA6, 4, 0, 8'h00, 8'h00, got);
        do_load(8'hC1);
        rst = 1'b1;
        tick(1);
        chk("midrst_miso",     bus.spi_miso_o, 0);
        chk("midrst_tx_ready", bus.tx_ready_o, 1);
        chk("midrst_rx_data",  bus.rx_data_bo, 0);
        chk("midrst_rx_valid", bus.rx_valid_o, 0);
        chk("midrst_busy",     bus.busy_o,     0);
        rst = 1'b0;
        bus.spi_cs_i = 1'b1;
        tick(6);
        chk("midrst_rx_pulses", rx_cnt - c0, 0);
        do_load(8'h4B);
        c0 = rx_cnt;
        frame_begin();
        xfer_byte(8'hC4, 8, 0, 8'h00, 8'h00, got);
        frame_end();
        chk("post_rst_miso", got, 8'h4B);
        chk("post_rst_rx_pulses", rx_cnt - c0, 1);
        expect_rx("post_rst_rx", 8'hC4);

        // Randomized frames against a byte-level model:
        //  - each byte sent is the pending loaded byte if any, else DEFAULT_TX,
        //    and taking it empties the holding register;
        //  - after the final byte of a frame the slave takes the next byte
        //    anyway, so anything loaded during that byte is dropped.
        begin
            logic [7:0] pend;
            bit         pv;
            logic [7:0] exp_rx[$];
            pv   = 1'b0;
            pend = '0;
            for (int f = 0; f < 25; f++) begin
                int npre, nb;
                npre = $urandom_range(0, 2);
                for (int k = 0; k < npre; k++) begin
                    pend = 8'($urandom);
                    pv   = 1'b1;
                    do_load(pend);
                end
                chk($sformatf("rnd%0d_ready_pre", f), bus.tx_ready_o, !pv);
                nb = $urandom_range(1, 3);
                exp_rx.delete();
                c0 = rx_cnt;
                frame_begin();
                for (int b = 0; b < nb; b++) begin
                    logic [7:0] m, e, l0, l1;
                    int         nl;
                    m  = 8'($urandom);
                    l0 = 8'($urandom);
                    l1 = 8'($urandom);
                    nl = $urandom_range(0, 2);
                    e  = pv ? pend : C_DEFAULT_TX;
                    pv = 1'b0;
                    xfer_byte(m, 8, nl, l0, l1, got);
                    if (nl >= 1) begin pend = l0; pv = 1'b1; end
                    if (nl >= 2) pend = l1;
                    chk($sformatf("rnd%0d_b%0d_miso", f, b), got, e);
                    exp_rx.push_back(m);
                end
                frame_end();
                pv = 1'b0;
                chk($sformatf("rnd%0d_ready_post", f), bus.tx_ready_o, 1);
                chk($sformatf("rnd%0d_rx_pulses", f), rx_cnt - c0, nb);
                foreach (exp_rx[i]) expect_rx($sformatf("rnd%0d_rx%0d", f, i), exp_rx[i]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
